// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry in-order writeback buffer behind the ALU.
// Drains to the regfile port, tracks arch flags and resolves branches.
module alu_wb_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_result,
   input  logic               in_carry,
   input  logic               in_zero,
   input  logic               in_sign,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic               in_reg_we,
   input  logic               in_flag_we,
   input  logic [2:0]         in_br_cond,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [RADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               wb_we,
   output logic [2:0]         flags_q,
   output logic               br_taken,
   output logic [1:0]         occupancy
);

   typedef struct packed {
      logic [DATA_W-1:0]  result;
      logic               carry;
      logic               zero;
      logic               sign;
      logic [RADDR_W-1:0] rd;
      logic               reg_we;
      logic               flag_we;
      logic [2:0]         br_cond;
   } entry_t;

   entry_t     slot_q [2];
   entry_t     slot_d [2];
   entry_t     head;
   entry_t     in_entry;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic [2:0] flags_d;
   logic       br_taken_q, br_taken_d;
   logic       push, pop;

   function automatic logic cond_eval(
      input logic [2:0] c,
      input logic       cf,
      input logic       zf,
      input logic       sf
   );
      logic r;
      r = 1'b0;
      case (c)
         3'b001:  r = zf;
         3'b010:  r = ~zf;
         3'b011:  r = sf;
         3'b100:  r = ~sf;
         3'b101:  r = cf;
         3'b110:  r = ~cf;
         3'b111:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign head      = slot_q[rd_ptr_q];
   assign in_ready  = ~rst & (count_q != 2'd2);
   assign wb_valid  = (count_q != 2'd0);
   assign wb_addr   = head.rd;
   assign wb_data   = head.result;
   assign wb_we     = head.reg_we & (head.rd != '0);
   assign br_taken  = br_taken_q;
   assign occupancy = count_q;
   assign push      = in_valid & in_ready;
   assign pop       = wb_valid & wb_ready;

   // Pack the incoming ALU entry
   always_comb begin
      in_entry         = '0;
      in_entry.result  = in_result;
      in_entry.carry   = in_carry;
      in_entry.zero    = in_zero;
      in_entry.sign    = in_sign;
      in_entry.rd      = in_rd;
      in_entry.reg_we  = in_reg_we;
      in_entry.flag_we = in_flag_we;
      in_entry.br_cond = in_br_cond;
   end

   // Next-state: buffer push/pop, flag update and branch resolve
   always_comb begin
      slot_d     = slot_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      flags_d    = flags_q;
      br_taken_d = 1'b0;
      if (push) begin
         slot_d[wr_ptr_q] = in_entry;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         br_taken_d = cond_eval(head.br_cond, head.carry,
                                head.zero, head.sign);
         if (head.flag_we)
            flags_d = {head.carry, head.zero, head.sign};
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++)
            slot_q[i] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         flags_q    <= 3'b000;
         br_taken_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flags_q    <= flags_d;
         br_taken_q <= br_taken_d;
      end
   end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the ALU.
- Captures the ALU result, its carry/zero/sign flags, the destination register and per-instruction control into a 2-entry in-order buffer.
- Drains the buffer to the register-file write port under a valid/ready handshake.
- On each drain it updates the architectural flag register and resolves flag-based branches.

Parameters:
DATA_W, 32, width of ALU result and writeback data
RADDR_W, 5, register address width

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU output entry valid
in_ready  output  1  stage can accept an entry this cycle
in_result  input  DATA_W  ALU result
in_carry  input  1  ALU carry flag
in_zero  input  1  ALU zero flag
in_sign  input  1  ALU sign flag
in_rd  input  RADDR_W  destination register
in_reg_we  input  1  entry writes a register
in_flag_we  input  1  entry updates the flag register
in_br_cond  input  3  branch condition: 000 none, 001 Z, 010 NZ, 011 S, 100 NS, 101 C, 110 NC, 111 always
wb_valid  output  1  head entry presented to the register file
wb_ready  input  1  register file accepts the head entry
wb_addr  output  RADDR_W  head destination register
wb_data  output  DATA_W  head result
wb_we  output  1  head write enable
flags_q  output  3  architectural flags {carry, zero, sign}
br_taken  output  1  one-cycle pulse: the popped entry's branch is taken
occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (async, rst=1): count=0, read/write pointers=0, both slots cleared to 0, flags_q=3'b000, br_taken=0.
- Outputs during reset: wb_valid=0, wb_addr=0, wb_data=0, wb_we=0, in_ready=0.
  - in_ready is held at 0 while rst is asserted.
  - in_ready rises in the first cycle after rst deasserts.
- Reset mid-operation discards all held entries; no writeback or flag update occurs for them.
- Storage is a 2-slot circular buffer with 1-bit read/write pointers that wrap 1->0.
- Push happens when in_valid & in_ready; pop happens when wb_valid & wb_ready.
- in_ready = (count != 2). It is derived from registered state only, with no combinational path from wb_ready.
- wb_valid = (count != 0). wb_addr/wb_data come from the head slot combinationally from registers.
- wb_we = head.reg_we & (head.rd != 0). Writes to r0 are suppressed, but the entry still pops normally.
- Latency: an entry pushed at edge N is visible on wb_* in the cycle after N; minimum input-to-writeback latency is 1 cycle.
- Count update rules:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged; both pointers advance.
  - count=2: no push is possible (in_ready=0); a pop frees a slot for the next cycle.
  - count=0: wb_ready is ignored.
- Entries drain strictly in push order.
- At the pop edge:
  - If head.flag_we=1, flags_q <= {head.carry, head.zero, head.sign}; otherwise flags_q holds.
  - br_taken <= the condition evaluated on the head entry's own captured flags, not on flags_q.
  - br_taken is 0 for cond 000 and 1 for cond 111.
- Cycles without a pop: br_taken <= 0, so br_taken is a one-cycle pulse per taken pop.
- Back-to-back pops with taken branches produce br_taken high on consecutive cycles.
- occupancy = count.

Test Plan:
1. Reset then single push: result=32'h0000_0005, rd=3, reg_we=1, flag_we=1, flags C=1 Z=0 S=0, wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=5, wb_we=1; after the pop edge flags_q=3'b100 and occupancy=0.
2. Fill with wb_ready=0: push results A and B -> occupancy=2, in_ready=0; a third push is not accepted. Then raise wb_ready -> A pops, then B pops, in order; occupancy returns to 0.
3. Simultaneous push and pop at occupancy=1 for 6 consecutive cycles -> occupancy stays 1, pointers wrap, and the wb_data sequence matches the push order exactly.
4. Branches: pop an entry with result=0, Z=1, cond=001, flag_we=0 -> br_taken=1 for exactly one cycle and flags_q unchanged. Next pop with cond=010 and Z=1 -> br_taken=0.
5. Write to r0: rd=0, reg_we=1, data=32'hDEAD_BEEF -> wb_valid=1, wb_we=0, and the entry pops.
6. Assert rst asynchronously with occupancy=2 and flags_q=3'b011 -> immediately wb_valid=0, in_ready=0, occupancy=0, flags_q=0, br_taken=0; no stale entry appears after release.
